// File: rtl/cnn_dma_pkg.sv
// cnn_dma_pkg: FSM state types, AXI attribute constants and bus widths
// shared by the CNN DMA master and its beat counter.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_BURST_BITS
`define AXI_BURST_BITS 2
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_RESP_BITS
`define AXI_RESP_BITS 2
`endif

package cnn_dma_pkg;
   localparam int BEATS_LOG2 = 2;
   localparam logic [2:0] AXI_SIZE_4B = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      R_IDLE, R_ADDR, R_DATA, R_RESP
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE, W_ADDR, W_DATA, W_RESP
   } wr_state_t;
endpackage

// File: rtl/cnn_dma_beat_ctr.sv
// cnn_dma_beat_ctr: 2-bit burst beat counter with clear and increment;
// last flags the final beat position of a 4-beat burst.
module cnn_dma_beat_ctr
   import cnn_dma_pkg::*;
(
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic inc,
   output logic [BEATS_LOG2-1:0] cnt,
   output logic last
);
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc)
         cnt <= cnt + 1'b1;
   end

   assign last = &cnt;
endmodule

// File: rtl/cnn_dma_master.sv
// cnn_dma_master: AXI4 master moving 128-bit CNN operands as 4-beat INCR bursts.
// Optional completion interrupt enabled by defining CNN_DMA_IRQ_EN.
module cnn_dma_master
   import cnn_dma_pkg::*;
#(
   parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = 4'd2,
   parameter int BEATS = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic rd_req_valid,
   output logic rd_req_ready,
   input  logic [31:0] rd_addr,
   output logic rd_resp_valid,
   input  logic rd_resp_ready,
   output logic [127:0] rd_data,
   output logic rd_err,
   input  logic wr_req_valid,
   output logic wr_req_ready,
   input  logic [31:0] wr_addr,
   input  logic [127:0] wr_data,
   output logic wr_done,
   output logic wr_err,
`ifdef CNN_DMA_IRQ_EN
   output logic dma_interrupt,
   input  logic irq_clr,
`endif
   output logic [`AXI_ID_BITS-1:0] awid,
   output logic [`AXI_ADDR_BITS-1:0] awaddr,
   output logic [`AXI_LEN_BITS-1:0] awlen,
   output logic [`AXI_SIZE_BITS-1:0] awsize,
   output logic [`AXI_BURST_BITS-1:0] awburst,
   output logic awvalid,
   input  logic awready,
   output logic [`AXI_DATA_BITS-1:0] wdata,
   output logic [`AXI_STRB_BITS-1:0] wstrb,
   output logic wlast,
   output logic wvalid,
   input  logic wready,
   input  logic [`AXI_ID_BITS-1:0] bid,
   input  logic [`AXI_RESP_BITS-1:0] bresp,
   input  logic bvalid,
   output logic bready,
   output logic [`AXI_ID_BITS-1:0] arid,
   output logic [`AXI_ADDR_BITS-1:0] araddr,
   output logic [`AXI_LEN_BITS-1:0] arlen,
   output logic [`AXI_SIZE_BITS-1:0] arsize,
   output logic [`AXI_BURST_BITS-1:0] arburst,
   output logic arvalid,
   input  logic arready,
   input  logic [`AXI_ID_BITS-1:0] rid,
   input  logic [`AXI_DATA_BITS-1:0] rdata,
   input  logic [`AXI_RESP_BITS-1:0] rresp,
   input  logic rlast,
   input  logic rvalid,
   output logic rready
);
   rd_state_t rd_state, rd_next;
   wr_state_t wr_state, wr_next;
   logic live;
   logic rd_ovf;
   logic [BEATS_LOG2-1:0] rd_cnt, wr_cnt;
   logic rd_last, wr_last;
   logic rd_acc, wr_acc, ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic [127:0] wr_buf;
   logic unused_ok;

   assign unused_ok = ^{bid, rid};

   assign arid    = MASTER_ID;
   assign awid    = MASTER_ID;
   assign arlen   = `AXI_LEN_BITS'(BEATS - 1);
   assign awlen   = `AXI_LEN_BITS'(BEATS - 1);
   assign arsize  = AXI_SIZE_4B;
   assign awsize  = AXI_SIZE_4B;
   assign arburst = AXI_BURST_INCR;
   assign awburst = AXI_BURST_INCR;
   assign wstrb   = {`AXI_STRB_BITS{1'b1}};
   assign wdata   = wr_buf[{wr_cnt, 5'd0} +: 32];

   assign rd_acc = rd_req_valid && rd_req_ready;
   assign wr_acc = wr_req_valid && wr_req_ready;
   assign ar_hs  = arvalid && arready;
   assign r_hs   = rready && rvalid;
   assign aw_hs  = awvalid && awready;
   assign w_hs   = wvalid && wready;
   assign b_hs   = bready && bvalid;

   // Holds command readiness low until the first edge after reset release
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) live <= 1'b0;
      else         live <= 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_state <= R_IDLE;
         wr_state <= W_IDLE;
      end else begin
         rd_state <= rd_next;
         wr_state <= wr_next;
      end
   end

   always_comb begin
      rd_next = rd_state;
      unique case (rd_state)
         R_IDLE: if (rd_acc) rd_next = R_ADDR;
         R_ADDR: if (arready) rd_next = R_DATA;
         R_DATA: if (rvalid && rlast) rd_next = R_RESP;
         R_RESP: if (rd_resp_ready) rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   always_comb begin
      rd_req_ready  = 1'b0;
      arvalid       = 1'b0;
      rready        = 1'b0;
      rd_resp_valid = 1'b0;
      unique case (rd_state)
         R_IDLE: rd_req_ready = live;
         R_ADDR: arvalid = 1'b1;
         R_DATA: rready = 1'b1;
         R_RESP: rd_resp_valid = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      wr_next = wr_state;
      unique case (wr_state)
         W_IDLE: if (wr_acc) wr_next = W_ADDR;
         W_ADDR: if (awready) wr_next = W_DATA;
         W_DATA: if (wready && wr_last) wr_next = W_RESP;
         W_RESP: if (bvalid) wr_next = W_IDLE;
         default: wr_next = W_IDLE;
      endcase
   end

   always_comb begin
      wr_req_ready = 1'b0;
      awvalid      = 1'b0;
      wvalid       = 1'b0;
      wlast        = 1'b0;
      bready       = 1'b0;
      unique case (wr_state)
         W_IDLE: wr_req_ready = live;
         W_ADDR: awvalid = 1'b1;
         W_DATA: begin
            wvalid = 1'b1;
            wlast  = wr_last;
         end
         W_RESP: bready = 1'b1;
         default: ;
      endcase
   end

   // Overflow marks a full burst seen without RLAST; later beats are dropped
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         araddr  <= '0;
         rd_data <= '0;
         rd_err  <= 1'b0;
         rd_ovf  <= 1'b0;
      end else begin
         if (rd_acc) begin
            araddr <= rd_addr;
            rd_err <= 1'b0;
            rd_ovf <= 1'b0;
         end
         if (r_hs) begin
            if (!rd_ovf)
               rd_data[{rd_cnt, 5'd0} +: 32] <= rdata;
            if (rd_last && !rlast)
               rd_ovf <= 1'b1;
            if (rresp != AXI_RESP_OKAY || rd_ovf || (rlast && !rd_last))
               rd_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         awaddr  <= '0;
         wr_buf  <= '0;
         wr_done <= 1'b0;
         wr_err  <= 1'b0;
      end else begin
         wr_done <= b_hs;
         if (wr_acc) begin
            awaddr <= wr_addr;
            wr_buf <= wr_data;
         end
         if (b_hs)
            wr_err <= (bresp != AXI_RESP_OKAY);
      end
   end

`ifdef CNN_DMA_IRQ_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         dma_interrupt <= 1'b0;
      else if (wr_done)
         dma_interrupt <= 1'b1;
      else if (irq_clr)
         dma_interrupt <= 1'b0;
   end
`endif

   cnn_dma_beat_ctr u_rd_ctr (
      .clk    (clk),
      .resetn (resetn),
      .clr    (ar_hs),
      .inc    (r_hs),
      .cnt    (rd_cnt),
      .last   (rd_last)
   );

   cnn_dma_beat_ctr u_wr_ctr (
      .clk    (clk),
      .resetn (resetn),
      .clr    (aw_hs),
      .inc    (w_hs),
      .cnt    (wr_cnt),
      .last   (wr_last)
   );
endmodule

// File: doc/cnn_dma_master.md
# cnn_dma_master

AXI4 master that moves 128-bit CNN operands and results between system memory and the CNN accelerator as fixed 4-beat INCR bursts of 32-bit words. It sits between the CNN datapath and a master port of the AXI interconnect, the initiator counterpart of the CNN slave wrapper. Read and write engines are independent and may be active at the same time. An optional completion interrupt is provided for the CPU.

## Interface
Parameters:
- MASTER_ID, default 4'd2: constant value driven on ARID and AWID.
- BEATS, default 4: burst length. ARLEN and AWLEN are BEATS-1. Only the value 4 is supported.

Ports:
- clk  in  1  single clock; everything is sampled on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- rd_req_valid / rd_req_ready  in/out  1/1  read command handshake.
- rd_addr  in  32  burst base address; must be 16-byte aligned.
- rd_resp_valid / rd_resp_ready  out/in  1/1  read result handshake.
- rd_data  out  128  assembled words; beat0 occupies [31:0].
- rd_err  out  1  qualified by rd_resp_valid.
- wr_req_valid / wr_req_ready  in/out  1/1  write command handshake.
- wr_addr  in  32  burst base address; must be 16-byte aligned.
- wr_data  in  128  result to store; [31:0] is sent first.
- wr_done  out  1  one-cycle pulse when the write completes.
- wr_err  out  1  qualified by wr_done.
- dma_interrupt  out  1  present only with the macro (see Configuration).
- irq_clr  in  1  present only with the macro.
- AXI master channels: AW (ID, ADDR, LEN, SIZE, BURST, VALID, READY), W (DATA, STRB, LAST, VALID, READY), B (ID, RESP, VALID, READY), AR (ID, ADDR, LEN, SIZE, BURST, VALID, READY), R (ID, DATA, RESP, LAST, VALID, READY). Widths come from the `AXI_*_BITS` defines.

## Operation
Fixed AXI attributes:
- SIZE is 3'b010.
- BURST is 2'b01 (INCR).
- WSTRB is 4'hF.

Read FSM, states R_IDLE, R_ADDR, R_DATA, R_RESP:
- R_IDLE: rd_req_ready=1. When rd_req_valid is high, latch rd_addr, clear the error flag, go to R_ADDR.
- R_ADDR: ARVALID=1 and ARADDR held stable. On ARREADY, load the beat counter to 0 and go to R_DATA.
- R_DATA: RREADY=1. Each R handshake writes RDATA into rd_data word[cnt] and increments cnt.
  - RRESP!=0 on any beat sets the sticky error flag.
  - The burst ends on the beat with RLAST, then go to R_RESP.
  - If RLAST arrives with cnt!=3, set the error flag.
  - Beats received after cnt=3 without RLAST are dropped and set the error flag.
- R_RESP: rd_resp_valid=1, with rd_data and rd_err held. On rd_resp_ready, go to R_IDLE.

Write FSM, states W_IDLE, W_ADDR, W_DATA, W_RESP:
- W_IDLE: wr_req_ready=1. When wr_req_valid is high, latch wr_addr and wr_data, go to W_ADDR.
- W_ADDR: AWVALID=1. On AWREADY, go to W_DATA with cnt=0.
- W_DATA: WVALID=1 and WDATA=word[cnt]. WLAST=1 when cnt==3. Each W handshake increments cnt. The handshake with WLAST goes to W_RESP.
- W_RESP: BREADY=1. On BVALID, wr_done pulses for one cycle, wr_err=(BRESP!=0), go to W_IDLE.

Concurrency and response checks:
- The read and write FSMs never block each other.
- BID and RID are not checked.

## Timing
- Reset values: every VALID and READY output is 0. ARADDR/AWADDR=0, WDATA=0, WLAST=0, rd_data=0, rd_err=0, wr_done=0, wr_err=0, dma_interrupt=0. FSMs are in IDLE. rd_req_ready=1 and wr_req_ready=1 in the first cycle after reset is released.
- Asserting resetn low mid-burst aborts immediately: all VALIDs drop asynchronously and the latched command is discarded.
- A VALID, once asserted, stays high with its payload stable until the handshake. A VALID never depends combinationally on the matching READY.
- Minimum read latency: command accepted at cycle 0, ARVALID at cycle 1, beats at cycles 2–5 with zero wait states, rd_resp_valid at cycle 6.
- Minimum write latency: command accepted at cycle 0, AWVALID at cycle 1, W beats at cycles 2–5, BREADY high from cycle 6, wr_done pulses the cycle after the B handshake.
- Backpressure: RREADY stays 1 throughout R_DATA. A deasserted WREADY stalls cnt with WDATA held.
- Back-to-back: a new command is accepted in the cycle after R_RESP or W_RESP completes. No command is accepted during the same cycle as the handshake that completes the previous one.

## Configuration
- CNN_DMA_IRQ_EN defined:
  - dma_interrupt is a level output, set the cycle after any wr_done pulse.
  - It is cleared by irq_clr. If set and clear happen in the same cycle, set wins.
  - irq_clr is an input.
- CNN_DMA_IRQ_EN undefined: the dma_interrupt and irq_clr ports are absent and there is no interrupt logic.

## Structure
- Package cnn_dma_pkg contains:
  - rd_state_t and wr_state_t enums.
  - Constants AXI_SIZE_4B=3'b010, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00.
  - BEATS_LOG2=2.
- One sub-module, cnn_dma_beat_ctr: 2-bit counter with clear, increment, count and last outputs. It is instantiated once per FSM.

## Test plan
- Read, zero wait: rd_addr=32'h0000_1000 and a slave returning 11111111, 22222222, 33333333, 44444444 → ARADDR=0x1000, ARLEN=3; rd_data=128'h44444444_33333333_22222222_11111111; rd_err=0; rd_resp_valid at cycle 6.
- Write with WREADY low for 2 cycles on beat 1: wr_data=128'hDDDD…_AAAA… → W beats in order A,B,C,D; WDATA held during the stall; WLAST only on beat 3; wr_done pulses once.
- Error paths:
  - RRESP=2'b10 on beat 2 → rd_err=1 with full data returned.
  - BRESP=2'b11 → wr_err=1.
  - RLAST on beat 1 → rd_err=1.
- Concurrent read and write issued in the same cycle with interleaved slave responses → both complete with correct data and neither READY blocks.
- Reset mid-burst: resetn low after beat 1 → ARVALID/RREADY go to 0 at once; the next read after reset completes normally.
- With CNN_DMA_IRQ_EN defined: dma_interrupt rises the cycle after wr_done. If irq_clr is asserted in the same cycle as a new wr_done, dma_interrupt stays 1.
